piso_arb_ctrl: RTL and testbench
================================

PISO_ARB_CTRL -- requirements
Module: piso_arb_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: parallel word width in bits; legal range 2..32.
REQ-002 The block SHALL have parameter DIV, default 2: clk cycles each serial bit is held; legal range 1..16.
REQ-003 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-004 Port clk, input, 1 bit: sole clock, rising edge.
REQ-005 Port rst, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-006 Port req0_valid, input, 1 bit: requester 0 has a word to send.
REQ-007 Port req0_data, input, WIDTH bits: requester 0 parallel word.
REQ-008 Port req0_ready, output, 1 bit: requester 0 word accepted this cycle.
REQ-009 Ports req1_valid, req1_data and req1_ready SHALL be identical in direction, width and meaning to the requester-0 ports, for requester 1.
REQ-010 Port sout, output, 1 bit: serial data, MSB first.
REQ-011 Port sout_valid, output, 1 bit: sout carries a data bit.
REQ-012 Port sout_last, output, 1 bit: sout carries the LSB (last bit) of the word.
REQ-013 Port sout_src, output, 1 bit: index of the requester that owns the word being shifted.
REQ-014 Port busy, output, 1 bit: a word is being serialized.

Function
REQ-015 The FSM SHALL have two states: IDLE and SHIFT.
REQ-016 In IDLE, the grant SHALL go to the only valid requester, or to the requester named by the priority pointer prio when both are valid.
REQ-017 reqX_ready SHALL be combinational: 1 only in IDLE, with reqX_valid=1 and grant=X; at most one ready per cycle.
REQ-018 A transfer occurs when valid and ready are both 1; the word SHALL then be captured into shreg, src set to the grant, bit counter set to WIDTH-1, divider counter set to 0, and state set to SHIFT.
REQ-019 In SHIFT: sout=shreg[WIDTH-1], sout_valid=1, busy=1, sout_src=src.
REQ-020 The divider counter SHALL count 0..DIV-1; on DIV-1 it wraps to 0, shreg shifts left by 1 with a 0 fill, and the bit counter decrements.
REQ-021 sout_last SHALL be 1 for all DIV cycles of the final bit (bit counter = 0) and 0 otherwise.
REQ-022 On the divider wrap while the bit counter is 0, the state SHALL return to IDLE and prio SHALL be set to the requester not equal to src.
REQ-023 Latency: the first bit appears on sout in the cycle after the transfer; a word occupies exactly WIDTH*DIV SHIFT cycles.
REQ-024 At least one IDLE cycle SHALL occur between consecutive words, giving a minimum period of WIDTH*DIV+1 cycles.
REQ-025 In IDLE, sout, sout_valid, sout_last and busy SHALL all be 0, and sout_src SHALL hold its last value.
REQ-026 A requester deasserting valid before ready SHALL have no effect; req data SHALL be sampled only at the transfer.
REQ-027 Valid or data changes during SHIFT SHALL be ignored and SHALL NOT alter shreg.
REQ-028 If both requesters stay continuously valid, words SHALL strictly alternate 0,1,0,1,... with no starvation.
REQ-029 With DIV=1, the divider counter SHALL be a constant 0 and every SHIFT cycle SHALL shift.

Reset
REQ-030 When rst=0 at a clock edge, the block SHALL set state=IDLE, prio=0, src=0, shreg=0 and both counters to 0.
REQ-031 During reset, all outputs SHALL be 0, including both ready signals.
REQ-032 Reset in mid-word SHALL abort the word immediately; the word SHALL NOT be resumed, and the requester SHALL re-present it if it is still needed.

Verification
REQ-033 Reset, all inputs 0, rst low for 2 cycles -> every output 0; after rst goes high, outputs stay 0 while both valids are 0.
REQ-034 WIDTH=4, DIV=2, req0 sends 4'b1011 -> req0_ready high for 1 cycle; the next 8 cycles show sout=1,1,0,0,1,1,1,1 with sout_valid=1 and sout_src=0; sout_last=1 only on the last 2 cycles; then 1 cycle with busy=0.
REQ-035 Both valid from reset, req0=4'hA and req1=4'h5, held valid -> order is req0 (1010), then req1 (0101, sout_src=1), then req0 again; each word lasts 8 cycles with a 1-cycle IDLE gap.
REQ-036 Only req1 valid continuously -> req1 is served back-to-back every 9 cycles and req0_ready stays 0.
REQ-037 rst pulsed low during the 3rd bit of a req1 word -> the next cycle has sout_valid=0 and busy=0; with both valid afterwards, req0 is granted first (prio=0).
REQ-038 WIDTH=8, DIV=1, req0 sends 8'h81 -> sout=1,0,0,0,0,0,0,1 on 8 consecutive cycles, with sout_last on the 8th cycle only.

Source files
------------

// File: rtl/piso_arb_ctrl.sv
// Two-requester parallel-in/serial-out controller.
// A round-robin grant picks one requester's word, which is then shifted out
// MSB first with each bit held for DIV clock cycles. After each completed
// word the priority moves to the other requester, so two continuously valid
// requesters alternate. A reset in mid-word drops the word.
module piso_arb_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIV   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             sout_src,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Top values of the bit counter and of the divider counter.
    localparam logic [4:0] BIT_TOP = 5'(WIDTH - 1);
    localparam logic [3:0] DIV_TOP = 4'(DIV - 1);

    state_t           state_q;
    logic             prio_q;
    logic             src_q;
    logic [WIDTH-1:0] shreg_q;
    logic [4:0]       bitcnt_q;
    logic [3:0]       divcnt_q;

    logic             grant_s;
    logic             ready0_s;
    logic             ready1_s;
    logic             xfer_s;
    logic             shift_s;
    logic             div_wrap_s;

    // Grant: a lone valid requester wins, otherwise the priority pointer decides.
    always_comb begin
        grant_s = prio_q;
        if (req0_valid && !req1_valid) begin
            grant_s = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = prio_q;
        end
    end

    // Handshake and output decode; everything is forced low while reset is held.
    always_comb begin
        ready0_s   = rst && (state_q == IDLE) && req0_valid && (grant_s == 1'b0);
        ready1_s   = rst && (state_q == IDLE) && req1_valid && (grant_s == 1'b1);
        xfer_s     = ready0_s || ready1_s;
        shift_s    = rst && (state_q == SHIFT);
        div_wrap_s = (divcnt_q == DIV_TOP);
    end

    assign req0_ready = ready0_s;
    assign req1_ready = ready1_s;
    assign sout       = shift_s && shreg_q[WIDTH-1];
    assign sout_valid = shift_s;
    assign sout_last  = shift_s && (bitcnt_q == 5'd0);
    assign busy       = shift_s;
    // Source index survives into IDLE so a consumer can still see who sent last.
    assign sout_src   = rst && src_q;

    // Controller FSM: capture on transfer, shift on divider wrap, rotate priority at word end.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            src_q    <= 1'b0;
            shreg_q  <= '0;
            bitcnt_q <= 5'd0;
            divcnt_q <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer_s) begin
                        shreg_q  <= grant_s ? req1_data : req0_data;
                        src_q    <= grant_s;
                        bitcnt_q <= BIT_TOP;
                        divcnt_q <= 4'd0;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (div_wrap_s) begin
                        // With DIV=1 this branch is taken every cycle and divcnt stays 0.
                        divcnt_q <= 4'd0;
                        shreg_q  <= {shreg_q[WIDTH-2:0], 1'b0};
                        if (bitcnt_q == 5'd0) begin
                            state_q <= IDLE;
                            prio_q  <= ~src_q;
                        end else begin
                            bitcnt_q <= bitcnt_q - 5'd1;
                        end
                    end else begin
                        divcnt_q <= divcnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_arb_ctrl.sv
// Self-checking bench for piso_arb_ctrl: a 4-bit/DIV=2 instance driven by a
// vector table and corner-case sequences, plus an 8-bit/DIV=1 instance.
module tb_piso_arb_ctrl;

    localparam int WD = 8;   // SHIFT cycles per word for instance A (4 bits x DIV 2)

    logic clk;
    logic rst;

    logic       a_v0, a_v1, a_r0, a_r1;
    logic [3:0] a_d0, a_d1;
    logic       a_sout, a_sv, a_last, a_src, a_busy;

    logic       b_v0, b_v1, b_r0, b_r1;
    logic [7:0] b_d0, b_d1;
    logic       b_sout, b_sv, b_last, b_src, b_busy;

    int n_checks = 0;
    int n_errors = 0;
    logic last_src;

    // Scoreboard entries: {sout, sout_last, sout_src, busy, req1_ready, req0_ready}
    logic [5:0] sb_q[$];

    typedef struct {
        logic       v0;
        logic [3:0] d0;
        logic       v1;
        logic [3:0] d1;
        int         who;
        logic [3:0] word;
    } vec_t;

    piso_arb_ctrl #(.WIDTH(4), .DIV(2)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(a_v0), .req0_data(a_d0), .req0_ready(a_r0),
        .req1_valid(a_v1), .req1_data(a_d1), .req1_ready(a_r1),
        .sout(a_sout), .sout_valid(a_sv), .sout_last(a_last),
        .sout_src(a_src), .busy(a_busy)
    );

    piso_arb_ctrl #(.WIDTH(8), .DIV(1)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
        .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
        .sout(b_sout), .sout_valid(b_sv), .sout_last(b_last),
        .sout_src(b_src), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Serial-output monitor for instance A: every data cycle must match the scoreboard head.
    always @(negedge clk) begin
        if (a_sv === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_bit", 32'd1, 32'd0);
            end else begin
                check("serial_a", {a_sout, a_last, a_src, a_busy, a_r1, a_r0}, sb_q.pop_front());
            end
        end
    end

    task automatic push_word(input int who, input logic [3:0] w);
        for (int b = 3; b >= 0; b--) begin
            for (int d = 0; d < 2; d++) begin
                sb_q.push_back({w[b], (b == 0), who[0], 1'b1, 2'b00});
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        a_v0 = 1'b0; a_v1 = 1'b0; a_d0 = 4'h0; a_d1 = 4'h0;
        b_v0 = 1'b0; b_v1 = 1'b0; b_d0 = 8'h0; b_d1 = 8'h0;
        repeat (2) begin
            @(negedge clk);
            check("reset_outputs", {a_r0, a_r1, a_sout, a_sv, a_last, a_src, a_busy,
                                    b_r0, b_r1, b_sout, b_sv, b_last, b_src, b_busy}, 32'd0);
        end
        sb_q.delete();
        last_src = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {a_r0, a_r1, a_sout, a_sv, a_last, a_src, a_busy,
                                  b_r0, b_r1, b_sout, b_sv, b_last, b_src, b_busy}, 32'd0);
    endtask

    // Wait for the expected grant, queue its bit stream, then let the word drain.
    task automatic expect_word(input int who, input logic [3:0] w, input int exp_wait, input bit scramble);
        int   waited;
        logic r0, r1;
        waited = 0; r0 = 1'b0; r1 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            waited++;
            r0 = a_r0; r1 = a_r1;
            if (r0 || r1) break;
        end
        check("grant", {r1, r0}, (who != 0) ? 2'b10 : 2'b01);
        if (exp_wait > 0) check("grant_wait", waited, exp_wait);
        check("idle_outputs", {a_sv, a_busy, a_sout, a_last, a_src}, {4'b0000, last_src});
        push_word(who, w);
        last_src = who[0];
        if (scramble) begin
            @(posedge clk); #1;
            a_v0 = 1'b0; a_v1 = 1'b0;
            a_d0 = ~a_d0; a_d1 = ~a_d1;
        end
        repeat (WD) @(negedge clk);
        #1;
        check("drain", sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t       tbl[6];
        logic       r0, r1;
        logic [7:0] bw;

        rst = 1'b0;
        a_v0 = 1'b0; a_v1 = 1'b0; a_d0 = 4'h0; a_d1 = 4'h0;
        b_v0 = 1'b0; b_v1 = 1'b0; b_d0 = 8'h0; b_d1 = 8'h0;
        last_src = 1'b0;

        tbl[0] = '{1'b1, 4'b1011, 1'b0, 4'b0000, 0, 4'b1011};
        tbl[1] = '{1'b0, 4'b0000, 1'b1, 4'b0110, 1, 4'b0110};
        tbl[2] = '{1'b1, 4'hA,    1'b1, 4'h5,    0, 4'hA};
        tbl[3] = '{1'b1, 4'hF,    1'b0, 4'h3,    0, 4'hF};
        tbl[4] = '{1'b0, 4'h9,    1'b1, 4'h0,    1, 4'h0};
        tbl[5] = '{1'b1, 4'h1,    1'b0, 4'hE,    0, 4'h1};

        // Single words from a fresh reset; inputs are scrambled during SHIFT.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            @(posedge clk); #1;
            a_v0 = tbl[i].v0; a_d0 = tbl[i].d0;
            a_v1 = tbl[i].v1; a_d1 = tbl[i].d1;
            expect_word(tbl[i].who, tbl[i].word, 1, 1'b1);
        end

        // Both continuously valid: strict alternation with a one-cycle gap.
        do_reset();
        @(posedge clk); #1;
        a_v0 = 1'b1; a_d0 = 4'hA; a_v1 = 1'b1; a_d1 = 4'h5;
        expect_word(0, 4'hA, 1, 1'b0);
        expect_word(1, 4'h5, 1, 1'b0);
        expect_word(0, 4'hA, 1, 1'b0);
        expect_word(1, 4'h5, 1, 1'b0);

        // Only req1 valid: served every WD+1 cycles, req0_ready never rises.
        do_reset();
        @(posedge clk); #1;
        a_v1 = 1'b1; a_d1 = 4'b1001;
        expect_word(1, 4'b1001, 1, 1'b0);
        expect_word(1, 4'b1001, 1, 1'b0);
        expect_word(1, 4'b1001, 1, 1'b0);

        // Reset during the third bit of a req1 word aborts it; req0 wins afterwards.
        do_reset();
        @(posedge clk); #1;
        a_v1 = 1'b1; a_d1 = 4'b1100;
        r0 = 1'b0; r1 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            r0 = a_r0; r1 = a_r1;
            if (r0 || r1) break;
        end
        check("abort_grant", {r1, r0}, 2'b10);
        push_word(1, 4'b1100);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        a_v0 = 1'b1; a_d0 = 4'b0110; a_v1 = 1'b1;
        @(negedge clk);
        check("reset_mid_word", {a_r0, a_r1, a_sout, a_sv, a_last, a_src, a_busy}, 32'd0);
        sb_q.delete();
        last_src = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        expect_word(0, 4'b0110, 1, 1'b1);

        // WIDTH=8, DIV=1 instance: one bit per cycle, last only on the 8th.
        bw = 8'h81;
        @(posedge clk); #1;
        b_v0 = 1'b1; b_d0 = bw;
        r0 = 1'b0; r1 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            r0 = b_r0; r1 = b_r1;
            if (r0 || r1) break;
        end
        check("b_grant", {r1, r0}, 2'b01);
        @(posedge clk); #1;
        b_v0 = 1'b0; b_d0 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("b_serial", {b_sout, b_last, b_sv, b_busy, b_src}, {bw[7 - i], (i == 7), 1'b1, 1'b1, 1'b0});
        end
        @(negedge clk);
        check("b_gap", {b_sv, b_busy, b_last}, 3'b000);

        #1;
        check("final_queue", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
